// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: sample width, twiddle format, and
// the butterfly complex-multiply sequencer states.
package fft_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC   = 15;

    // One state per product cycle; LDR/LDI hand a result to the accumulator
    typedef enum logic [2:0] {
        IDLE,
        RR,
        II,
        LDR,
        RI,
        IR,
        LDI
    } state_t;

    // Q1.15 product back to sample width: plain truncation, wraps on overflow
    function automatic logic [DATA_W-1:0] trunc(input logic signed [2*DATA_W-1:0] p);
        return DATA_W'(p >>> FRAC);
    endfunction

endpackage

// File: rtl/q15_mult.sv
// Combinational signed multiply with fractional truncation.
// The top shares one instance across all four partial products.
module q15_mult #(
    parameter int DATA_W = 16,
    parameter int FRAC   = 15
) (
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] y,
    output logic        [DATA_W-1:0] p
);

    logic signed [2*DATA_W-1:0] prod;

    assign prod = x * y;
    // Drop FRAC fraction bits, keep DATA_W; (-1)*(-1) wraps to 0x8000
    assign p    = DATA_W'(prod >>> FRAC);

endmodule

// File: rtl/butterfly_cmul_seq.sv
// Sequential B*W complex multiplier feeding the butterfly add/sub stage.
// Real part emitted with Ld_R, imaginary part with Ld_I, 7 cycles per op.
module butterfly_cmul_seq #(
    parameter int DATA_W = 16,
    parameter int FRAC   = 15
) (
    input  logic              clk_MAC,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a_re,
    input  logic [DATA_W-1:0] a_im,
    input  logic [DATA_W-1:0] b_re,
    input  logic [DATA_W-1:0] b_im,
    input  logic [DATA_W-1:0] w_re,
    input  logic [DATA_W-1:0] w_im,
    output logic [DATA_W-1:0] out_BW,
    output logic [DATA_W-1:0] out_A,
    output logic              Ld_R,
    output logic              Ld_I,
    output logic              rst_signal,
    output logic              busy,
    output logic              done
);

    import fft_pkg::*;

    state_t            state, state_nxt;
    logic              accept;
    logic [DATA_W-1:0] a_re_q, a_im_q, b_re_q, b_im_q, w_re_q, w_im_q;
    logic [DATA_W-1:0] acc, acc_nxt;
    logic [DATA_W-1:0] mx, my, prod_t;

    assign accept = (state == IDLE) && start;

    // State register
    always_ff @(posedge clk_MAC or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Fixed walk through the four products; only IDLE waits on start
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RR;
            RR:      state_nxt = II;
            II:      state_nxt = LDR;
            LDR:     state_nxt = RI;
            RI:      state_nxt = IR;
            IR:      state_nxt = LDI;
            LDI:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand select for the single shared multiplier
    always_comb begin
        mx = b_re_q;
        my = w_re_q;
        case (state)
            II:      begin mx = b_im_q; my = w_im_q; end
            RI:      begin mx = b_re_q; my = w_im_q; end
            IR:      begin mx = b_im_q; my = w_re_q; end
            default: ;
        endcase
    end

    q15_mult #(.DATA_W(DATA_W), .FRAC(FRAC)) u_mult (
        .x (mx),
        .y (my),
        .p (prod_t)
    );

    // Accumulator: first product of each part loads, second adds/subtracts
    always_comb begin
        acc_nxt = acc;
        case (state)
            RR:      acc_nxt = prod_t;
            II:      acc_nxt = acc - prod_t;
            RI:      acc_nxt = prod_t;
            IR:      acc_nxt = acc + prod_t;
            default: ;
        endcase
    end

    // Operand latches (captured only on accept) and accumulator
    always_ff @(posedge clk_MAC or posedge rst) begin
        if (rst) begin
            a_re_q <= '0; a_im_q <= '0;
            b_re_q <= '0; b_im_q <= '0;
            w_re_q <= '0; w_im_q <= '0;
            acc    <= '0;
        end else begin
            acc <= acc_nxt;
            if (accept) begin
                a_re_q <= a_re; a_im_q <= a_im;
                b_re_q <= b_re; b_im_q <= b_im;
                w_re_q <= w_re; w_im_q <= w_im;
            end
        end
    end

    // Registered outputs, decoded one cycle early so they line up with
    // the LDR/LDI/RR state they belong to
    always_ff @(posedge clk_MAC or posedge rst) begin
        if (rst) begin
            out_BW     <= '0;
            out_A      <= '0;
            Ld_R       <= 1'b0;
            Ld_I       <= 1'b0;
            rst_signal <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            rst_signal <= accept;
            Ld_R       <= (state == II);
            Ld_I       <= (state == IR);
            done       <= (state == IR);
            busy       <= (state_nxt != IDLE);
            if (state == II) begin
                out_BW <= acc_nxt;
                out_A  <= a_re_q;
            end
            if (state == IR) begin
                out_BW <= acc_nxt;
                out_A  <= a_im_q;
            end
        end
    end

endmodule

// File: tb/tb_butterfly_cmul_seq.sv
// Self-checking bench for butterfly_cmul_seq: directed corners, reset
// abort, handshake, and randomized operands against a complex-math model.
module tb_butterfly_cmul_seq;

    logic        clk_MAC = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a_re, a_im, b_re, b_im, w_re, w_im;
    logic [15:0] out_BW, out_A;
    logic        Ld_R, Ld_I, rst_signal, busy, done;

    int total = 0;
    int bad   = 0;

    butterfly_cmul_seq dut (
        .clk_MAC    (clk_MAC),
        .rst        (rst),
        .start      (start),
        .a_re       (a_re),
        .a_im       (a_im),
        .b_re       (b_re),
        .b_im       (b_im),
        .w_re       (w_re),
        .w_im       (w_im),
        .out_BW     (out_BW),
        .out_A      (out_A),
        .Ld_R       (Ld_R),
        .Ld_I       (Ld_I),
        .rst_signal (rst_signal),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk_MAC = ~clk_MAC;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Q1.15 fractional product: exact product scaled by 2^-15, floored, wrapped
    function automatic logic [15:0] qmul(input logic [15:0] x, input logic [15:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return 16'(p >>> 15);
    endfunction

    task automatic all_zero(input string tag);
        chk(tag, {out_BW, out_A, Ld_R, Ld_I, rst_signal, busy, done}, 64'd0);
    endtask

    // One full operation from the accept edge; optionally pulses start
    // mid-operation, which must be ignored
    task automatic run_op(input string tag,
                          input logic [15:0] ar, input logic [15:0] ai,
                          input logic [15:0] br, input logic [15:0] bi,
                          input logic [15:0] wr, input logic [15:0] wi,
                          input bit mid);
        logic [15:0] exp_re, exp_im;
        logic [4:0]  exp_strb;
        exp_re = qmul(br, wr) - qmul(bi, wi);
        exp_im = qmul(br, wi) + qmul(bi, wr);
        @(negedge clk_MAC);
        a_re = ar; a_im = ai; b_re = br; b_im = bi; w_re = wr; w_im = wi;
        start = 1'b1;
        @(posedge clk_MAC); #1;
        start = 1'b0;
        // operands must already be latched
        a_re = 16'($urandom); a_im = 16'($urandom);
        b_re = 16'($urandom); b_im = 16'($urandom);
        w_re = 16'($urandom); w_im = 16'($urandom);
        for (int c = 1; c <= 7; c++) begin
            exp_strb = {c == 1, c == 3, c == 6, c == 6, c <= 6};
            chk($sformatf("%s strobes c%0d", tag, c),
                {rst_signal, Ld_R, Ld_I, done, busy}, exp_strb);
            if (c == 3) chk({tag, " real"}, {out_BW, out_A}, {exp_re, ar});
            if (c == 6) chk({tag, " imag"}, {out_BW, out_A}, {exp_im, ai});
            if (c == 7) chk({tag, " hold"}, {out_BW, out_A}, {exp_im, ai});
            if (mid && c == 3) start = 1'b1;
            if (mid && c == 4) start = 1'b0;
            @(posedge clk_MAC); #1;
        end
    endtask

    initial begin
        int n_rs, n_ldi, n_both, n_hit;
        logic busy7;

        rst = 1'b1; start = 1'b0;
        a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0;
        repeat (2) @(posedge clk_MAC);
        #1 all_zero("reset state");
        @(negedge clk_MAC) rst = 1'b0;

        // Directed corners
        run_op("unit", 16'h0100, 16'h0200, 16'h2000, 16'h1000, 16'h7FFF, 16'h0000, 1'b0);
        run_op("rotate", 16'h1234, 16'hFEDC, 16'h2000, 16'h1000, 16'h0000, 16'h4000, 1'b0);
        run_op("wrap", 16'h7FFF, 16'h8000, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b0);
        run_op("mid start", 16'h0055, 16'h00AA, 16'h4000, 16'hC000, 16'h5A82, 16'hA57E, 1'b1);

        // Reset two cycles into an operation aborts it at once
        @(negedge clk_MAC);
        b_re = 16'h2000; w_re = 16'h7FFF; start = 1'b1;
        @(posedge clk_MAC); #1 start = 1'b0;
        @(posedge clk_MAC); #2 rst = 1'b1;
        #1 all_zero("abort immediate");
        // start with rst held must be ignored
        @(negedge clk_MAC) start = 1'b1;
        @(posedge clk_MAC); #1 all_zero("start under rst");
        @(negedge clk_MAC) begin start = 1'b0; rst = 1'b0; end
        n_hit = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_MAC); #1;
            if (Ld_R || Ld_I || busy || rst_signal) n_hit++;
        end
        chk("no activity after abort", n_hit, 0);
        run_op("after abort", 16'h0100, 16'h0200, 16'h2000, 16'h1000, 16'h7FFF, 16'h0000, 1'b0);

        // start held high: one accept every 7 cycles
        @(negedge clk_MAC);
        b_re = 16'h1000; b_im = 16'h2000; w_re = 16'h4000; w_im = 16'h4000;
        start = 1'b1;
        n_rs = 0; n_ldi = 0; n_both = 0; busy7 = 1'bx;
        for (int c = 1; c <= 21; c++) begin
            @(posedge clk_MAC); #1;
            n_rs  += int'(rst_signal);
            n_ldi += int'(Ld_I);
            if (Ld_R && Ld_I) n_both++;
            if (c == 7) busy7 = busy;
        end
        start = 1'b0;
        chk("held start rst_signal count", n_rs, 3);
        chk("held start Ld_I count", n_ldi, 3);
        chk("held start Ld_R&Ld_I", n_both, 0);
        chk("held start busy k+7", busy7, 1'b0);
        repeat (2) @(posedge clk_MAC);
        #1 chk("idle after held start", busy, 1'b0);

        // Randomized operands
        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("rand%0d", i),
                   16'($urandom), 16'($urandom), 16'($urandom),
                   16'($urandom), 16'($urandom), 16'($urandom), bit'(i % 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
